timing_viol_monitor: RTL

- Next-generation timing-violation aggregator for DDR5 RCD timing-check submodules.
- Edge-detects per-channel violation flags and maintains saturating per-channel and total counters.
- Timestamps each violation event into a bounded log FIFO that firmware or the testbench drains through a valid/ready port.
- Raises a sticky interrupt; sits between the timing-check submodules and the CSR/firmware bridge.

---
 rtl/timing_viol_pkg.sv | 35 +++
 rtl/timing_viol_log_fifo.sv | 83 ++++++++
 rtl/timing_viol_monitor.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/timing_viol_pkg.sv
// Shared types and arithmetic helpers for the timing-violation monitor.
package timing_viol_pkg;

  localparam int unsigned DEF_N_CH = 8;
  localparam int unsigned DEF_TS_W = 32;
  localparam int unsigned MAX_CH   = 32;

  typedef struct packed {
    logic [DEF_TS_W-1:0] ts;
    logic [DEF_N_CH-1:0] vec;
  } log_entry_t;

  // Wide enough for any counter width plus any increment, then clamped.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [63:0] max_v);
    logic [63:0] sum;
    sum = a + b;
    if (sum > max_v) begin
      sat_add = max_v;
    end else begin
      sat_add = sum;
    end
  endfunction

  function automatic logic [5:0] popcount(input logic [MAX_CH-1:0] v);
    logic [5:0] c;
    c = 6'd0;
    for (int i = 0; i < MAX_CH; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/timing_viol_log_fifo.sv
// Synchronous event-log FIFO with flush; a push into a full FIFO only lands if a pop frees a slot.
module timing_viol_log_fifo
  import timing_viol_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 40
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [W-1:0]               din_i,
  input  logic                       pop_i,
  output logic [W-1:0]               dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          do_push_s, do_pop_s;

  assign empty_o = (lvl_q == {LW{1'b0}});
  assign full_o  = (lvl_q == LW'(DEPTH));
  assign level_o = lvl_q;
  assign dout_o  = mem_q[rd_q];

  // Pointer, occupancy and storage next-state.
  always_comb begin
    do_pop_s  = pop_i & ~empty_o;
    do_push_s = push_i & (~full_o | do_pop_s);
    mem_d     = mem_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    lvl_d     = lvl_q;
    if (flush_i) begin
      wr_d  = {AW{1'b0}};
      rd_d  = {AW{1'b0}};
      lvl_d = {LW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_d[wr_q] = din_i;
        wr_d        = wr_q + AW'(1'b1);
      end else begin
        wr_d = wr_q;
      end
      if (do_pop_s) begin
        rd_d = rd_q + AW'(1'b1);
      end else begin
        rd_d = rd_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   lvl_d = lvl_q + LW'(1'b1);
        2'b01:   lvl_d = lvl_q - LW'(1'b1);
        default: lvl_d = lvl_q;
      endcase
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {W{1'b0}};
      end
      wr_q  <= {AW{1'b0}};
      rd_q  <= {AW{1'b0}};
      lvl_q <= {LW{1'b0}};
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

endmodule

// File: rtl/timing_viol_monitor.sv
// Aggregates per-channel timing violations into saturating counters, a sticky irq and a timestamped log.
// Optional per-channel threshold detection is enabled with TIMING_VIOL_THRESH_EN.
module timing_viol_monitor
  import timing_viol_pkg::*;
#(
  parameter int unsigned N_CH      = 8,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned LOG_DEPTH = 16,
  parameter int unsigned TS_W      = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_CH-1:0]                viol_flags_i,
  input  logic [N_CH-1:0]                viol_mask_i,
  input  logic                           clr_i,
  output logic [N_CH*CNT_W-1:0]          cnt_o,
  output logic [CNT_W-1:0]               total_o,
  output logic [N_CH-1:0]                sat_o,
  output logic                           irq_o,
  output logic                           log_valid_o,
  input  logic                           log_ready_i,
  output logic [TS_W-1:0]                log_ts_o,
  output logic [N_CH-1:0]                log_vec_o,
  output logic                           log_ovf_o,
  output logic [$clog2(LOG_DEPTH):0]     log_level_o
`ifdef TIMING_VIOL_THRESH_EN
  ,
  input  logic [CNT_W-1:0]               thresh_i,
  output logic [N_CH-1:0]                thresh_hit_o
`endif
);

  localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  logic [N_CH-1:0]            prev_q, prev_d;
  logic [TS_W-1:0]            ts_q, ts_d;
  logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]           total_q, total_d;
  logic [N_CH-1:0]            sat_q, sat_d;
  logic                       irq_q, irq_d;
  logic                       ovf_q, ovf_d;
  logic [N_CH-1:0]            ev_s;
  logic                       push_s, pop_s, full_s, empty_s;
  logic [63:0]                sum_s;
  logic [63:0]                tot_sum_s;
`ifdef TIMING_VIOL_THRESH_EN
  logic [N_CH-1:0]            hit_q, hit_d;
  assign thresh_hit_o = hit_q;
`endif

  assign cnt_o       = cnt_q;
  assign total_o     = total_q;
  assign sat_o       = sat_q;
  assign irq_o       = irq_q;
  assign log_ovf_o   = ovf_q;
  assign log_valid_o = ~empty_s;
  assign pop_s       = log_valid_o & log_ready_i;

  // Edge detection, counters, sticky flags; clear wins over a coincident event.
  always_comb begin
    ev_s      = viol_flags_i & ~prev_q & ~viol_mask_i;
    push_s    = (|ev_s) & ~clr_i;
    prev_d    = viol_flags_i;
    ts_d      = ts_q + TS_W'(1'b1);
    cnt_d     = cnt_q;
    total_d   = total_q;
    sat_d     = sat_q;
    irq_d     = irq_q;
    ovf_d     = ovf_q;
    sum_s     = 64'd0;
    tot_sum_s = 64'd0;
`ifdef TIMING_VIOL_THRESH_EN
    hit_d     = hit_q;
`endif
    if (clr_i) begin
      cnt_d   = '0;
      total_d = {CNT_W{1'b0}};
      sat_d   = {N_CH{1'b0}};
      irq_d   = 1'b0;
      ovf_d   = 1'b0;
`ifdef TIMING_VIOL_THRESH_EN
      hit_d   = {N_CH{1'b0}};
`endif
    end else begin
      for (int i = 0; i < int'(N_CH); i++) begin
        sum_s    = sat_add(64'(cnt_q[i]), 64'(ev_s[i]), CNT_MAX);
        cnt_d[i] = sum_s[CNT_W-1:0];
        sat_d[i] = sat_q[i] | (cnt_d[i] == CNT_MAX[CNT_W-1:0]);
`ifdef TIMING_VIOL_THRESH_EN
        hit_d[i] = hit_q[i] | ((thresh_i != {CNT_W{1'b0}}) && (cnt_q[i] >= thresh_i));
`endif
      end
      tot_sum_s = sat_add(64'(total_q), 64'(popcount(MAX_CH'(ev_s))), CNT_MAX);
      total_d   = tot_sum_s[CNT_W-1:0];
      ovf_d     = ovf_q | (push_s & full_s & ~pop_s);
`ifdef TIMING_VIOL_THRESH_EN
      irq_d     = irq_q | (|ev_s) | (|(hit_d & ~hit_q));
`else
      irq_d     = irq_q | (|ev_s);
`endif
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= {N_CH{1'b0}};
      ts_q    <= {TS_W{1'b0}};
      cnt_q   <= '0;
      total_q <= {CNT_W{1'b0}};
      sat_q   <= {N_CH{1'b0}};
      irq_q   <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef TIMING_VIOL_THRESH_EN
      hit_q   <= {N_CH{1'b0}};
`endif
    end else begin
      prev_q  <= prev_d;
      ts_q    <= ts_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      sat_q   <= sat_d;
      irq_q   <= irq_d;
      ovf_q   <= ovf_d;
`ifdef TIMING_VIOL_THRESH_EN
      hit_q   <= hit_d;
`endif
    end
  end

  timing_viol_log_fifo #(
    .DEPTH (LOG_DEPTH),
    .W     (TS_W + N_CH)
  ) u_log (
    .clk     (clk),
    .rst     (rst),
    .flush_i (clr_i),
    .push_i  (push_s),
    .din_i   ({ts_q, ev_s}),
    .pop_i   (pop_s),
    .dout_o  ({log_ts_o, log_vec_o}),
    .full_o  (full_s),
    .empty_o (empty_s),
    .level_o (log_level_o)
  );

endmodule
